// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
//   Each produces one bit per cycle. A final FIX cycle applies the signs and
//   writes HI/LO. MTHI/MTLO write HI/LO in the cycle they are accepted.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        request, only sampled while busy=0
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         rs / rt operands, latched at the accepting edge
//   busy         mul/div in progress (MUL, DIV or FIX state)
//   done         one-cycle pulse after HI/LO are written by a mul/div
//   div_by_zero  last completed divide had a zero divisor
//   hi, lo       architectural HI / LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    // Mul: {partial product high half, remaining multiplier bits}.
    // Div: {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   araw;      // original dividend for the b=0 result
    logic               sgn_q;     // negate product / quotient
    logic               sgn_r;     // negate remainder
    logic               is_div;

    // Operand decode at the accepting edge
    logic               md_start;
    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign md_start = start && !op[2];
    assign sgn_op   = !op[0];
    assign a_mag    = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (sgn_op && b[WIDTH-1]) ? -b : b;

    wire last = (cnt == CW'(WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (md_start) state_nx = op[1] ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (last) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != S_IDLE);
    end

    // ---------------- iteration steps ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_nx;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_add = acc[0] ? {1'b0, opnd} : '0;
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};

        // Restoring step: bring the next dividend bit into the remainder and
        // subtract the divisor if it fits. The quotient bit enters at the LSB.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_nx    = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fix = sgn_q ? -acc : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (opnd == '0) begin
                res_hi = araw;
                res_lo = '1;
            end else begin
                res_hi = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                res_lo = sgn_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            end
        end
    end

    // ---------------- datapath / architectural registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            araw        <= '0;
            sgn_q       <= 1'b0;
            sgn_r       <= 1'b0;
            is_div      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        cnt         <= '0;
                        araw        <= a;
                        sgn_q       <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_r       <= sgn_op & a[WIDTH-1];
                        is_div      <= op[1];
                        div_by_zero <= 1'b0;
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                S_MUL: begin
                    acc <= mul_nx;
                    cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    acc <= div_nx;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    if (is_div && opnd == '0) div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference architectural state
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;

    // Plain-arithmetic reference for every op
    task automatic model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy, r64;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin r64 = 64'(sx * sy); {m_hi, m_lo} = r64; m_dz = 1'b0; end
            3'd1: begin r64 = ux * uy;      {m_hi, m_lo} = r64; m_dz = 1'b0; end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    m_hi = x; m_lo = '1; m_dz = 1'b1;
                end else if (o == 3'd2) begin
                    r64 = 64'(sx / sy); m_lo = r64[31:0];
                    r64 = 64'(sx % sy); m_hi = r64[31:0];
                    m_dz = 1'b0;
                end else begin
                    r64 = ux / uy; m_lo = r64[31:0];
                    r64 = ux % uy; m_hi = r64[31:0];
                    m_dz = 1'b0;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue a mul/div from a negedge; returns at the negedge where done is seen.
    // lat counts rising edges after the start edge (-1 on timeout).
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int ign_at, output int lat, output int bad_busy, output int bad_hold);
        logic [W-1:0] ph, pl;
        ph = m_hi; pl = m_lo;
        lat = -1; bad_busy = 0; bad_hold = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        if (!busy || done) bad_busy++;
        if (hi !== ph || lo !== pl) bad_hold++;
        for (int j = 1; j <= 100; j++) begin
            if (j == ign_at) begin
                start = 1'b1; op = 3'b010; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = j;
                if (busy) bad_busy++;
                break;
            end
            if (!busy) bad_busy++;
            if (hi !== ph || lo !== pl) bad_hold++;
        end
        model_apply(o, x, y);
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [W-1:0] x);
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0; a = $urandom;
        model_apply(o, x, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
        nvec++; if (dbz !== 1'b0)  begin nerr++; $display("FAIL reset_dbz got %b want 0", dbz); end
        nvec++; if (hi !== '0)     begin nerr++; $display("FAIL reset_hi got %h want 0", hi); end
        nvec++; if (lo !== '0)     begin nerr++; $display("FAIL reset_lo got %h want 0", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [131:0] t [5];
        logic [2:0]   o;
        logic [W-1:0] x, y, eh, el;
        logic         ed;
        int           lat, bb, bh;
        t[0] = {3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        t[1] = {3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        t[2] = {3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        t[3] = {3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        t[4] = {3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        for (int i = 0; i < 5; i++) begin
            {o, x, y, eh, el, ed} = t[i];
            do_op(o, x, y, -1, lat, bb, bh);
            nvec++; if (lat != W + 1) begin nerr++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, W + 1); end
            nvec++; if (bb != 0) begin nerr++; $display("FAIL dir%0d_busy bad_cycles %0d want 0", i, bb); end
            nvec++; if (bh != 0) begin nerr++; $display("FAIL dir%0d_hold bad_cycles %0d want 0", i, bh); end
            nvec++; if (hi !== eh) begin nerr++; $display("FAIL dir%0d_hi got %h want %h", i, hi, eh); end
            nvec++; if (lo !== el) begin nerr++; $display("FAIL dir%0d_lo got %h want %h", i, lo, el); end
            nvec++; if (dbz !== ed) begin nerr++; $display("FAIL dir%0d_dbz got %b want %b", i, dbz, ed); end
        end
        // done is a single-cycle pulse
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse_width got %b want 0", done); end
    endtask

    task automatic test_div_zero();
        int lat, bb, bh;
        do_op(3'd3, 32'h7, 32'h0, -1, lat, bb, bh);
        nvec++; if (lat != W + 1) begin nerr++; $display("FAIL dz_latency got %0d want %0d", lat, W + 1); end
        nvec++; if (hi !== 32'h7) begin nerr++; $display("FAIL dz_hi got %h want 00000007", hi); end
        nvec++; if (lo !== 32'hFFFFFFFF) begin nerr++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        nvec++; if (dbz !== 1'b1) begin nerr++; $display("FAIL dz_flag got %b want 1", dbz); end
        do_mt(3'd5, 32'hCAFEF00D);
        nvec++; if (dbz !== 1'b1) begin nerr++; $display("FAIL dz_after_mtlo got %b want 1", dbz); end
        nvec++; if (lo !== 32'hCAFEF00D) begin nerr++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
        do_op(3'd2, 32'h8, 32'h2, -1, lat, bb, bh);
        nvec++; if (dbz !== 1'b0) begin nerr++; $display("FAIL dz_cleared got %b want 0", dbz); end
        nvec++; if (lo !== 32'h4) begin nerr++; $display("FAIL div8_lo got %h want 00000004", lo); end
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL div8_hi got %h want 00000000", hi); end
    endtask

    task automatic test_mthilo();
        int lat, bb, bh;
        logic [W-1:0] ph, pl;
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -1, lat, bb, bh);
        nvec++; if (lo !== 32'h80000000) begin nerr++; $display("FAIL minneg_lo got %h want 80000000", lo); end
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL minneg_hi got %h want 00000000", hi); end
        do_mt(3'd4, 32'h12345678);
        nvec++; if (hi !== 32'h12345678) begin nerr++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        nvec++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL mthi_flags got done=%b busy=%b want 0 0", done, busy); end
        // reserved op: nothing changes
        ph = m_hi; pl = m_lo;
        do_mt(3'd6, 32'hDEADBEEF);
        @(negedge clk);
        nvec++; if (busy !== 1'b0 || hi !== ph || lo !== pl) begin
            nerr++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, ph, pl); end
    endtask

    task automatic test_busy_ignore();
        int lat, bb, bh;
        do_op(3'd0, 32'h00012345, 32'hFFFF0003, 4, lat, bb, bh);
        nvec++; if (lat != W + 1) begin nerr++; $display("FAIL ign_latency got %0d want %0d", lat, W + 1); end
        nvec++; if (bh != 0) begin nerr++; $display("FAIL ign_hold bad_cycles %0d want 0", bh); end
        nvec++; if (hi !== m_hi || lo !== m_lo) begin
            nerr++; $display("FAIL ign_result got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        // a queued op would show up as a second done pulse
        repeat (W + 4) @(negedge clk);
        nvec++; if (busy !== 1'b0 || hi !== m_hi) begin nerr++; $display("FAIL ign_not_queued got busy=%b hi=%h want 0 %h", busy, hi, m_hi); end
    endtask

    task automatic test_random();
        int lat, bb, bh;
        logic [2:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if (o[2]) begin
                do_mt(o, x);
                nvec++; if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
                    nerr++; $display("FAIL rnd%0d_mt op=%0d got %h_%h busy=%b want %h_%h", i, o, hi, lo, busy, m_hi, m_lo); end
            end else begin
                do_op(o, x, y, -1, lat, bb, bh);
                nvec++; if (lat != W + 1 || bb != 0 || bh != 0) begin
                    nerr++; $display("FAIL rnd%0d_timing op=%0d lat=%0d busy_bad=%0d hold_bad=%0d want lat %0d", i, o, lat, bb, bh, W + 1); end
                nvec++; if (hi !== m_hi || lo !== m_lo || dbz !== m_dz) begin
                    nerr++; $display("FAIL rnd%0d op=%0d a=%h b=%h got %h_%h dz=%b want %h_%h dz=%b",
                                     i, o, x, y, hi, lo, dbz, m_hi, m_lo, m_dz); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        start = 1'b1; op = 3'd0; a = 32'h00001234; b = 32'h00005678;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'h8; b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done); end
        nvec++; if (hi !== '0 || lo !== '0) begin nerr++; $display("FAIL midrst_hilo got %h_%h want 0_0", hi, lo); end
        seen_done = 0;
        for (int j = 0; j < W + 8; j++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        nvec++; if (seen_done != 0) begin nerr++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen_done); end
        nvec++; if (hi !== '0 || lo !== '0) begin nerr++; $display("FAIL midrst_hilo_late got %h_%h want 0_0", hi, lo); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_zero();
        test_mthilo();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
